// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Grants at most one valid requester per cycle, registers the granted
// address/data and a one-hot register select, and drops (and counts)
// requests whose destination address is 0 or 15.
module regfile_write_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [4*NREQ-1:0]      req_addr,
  input  logic [DATA_W*NREQ-1:0] req_data,
  input  logic                   rf_stall,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wr_en,
  output logic [3:0]             wr_addr,
  output logic [13:0]            wr_sel,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   addr_err,
  output logic [7:0]             err_cnt
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [PW-1:0]     gnt_idx;
  logic [PW:0]       cand;
  logic              found;
  logic [3:0]        gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              addr_ok;

  logic [3:0]        addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[4*g +: 4];
    assign data_arr[g] = req_data[DATA_W*g +: DATA_W];
  end

  // Round-robin search starting at ptr; the candidate index wraps modulo NREQ
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!rf_stall && !found && req_valid[cand[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  // One-hot ready, granted payload and next pointer value
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = found && (gnt_idx == PW'(i));
    end
    gnt_addr = addr_arr[gnt_idx];
    gnt_data = data_arr[gnt_idx];
    addr_ok  = (gnt_addr != 4'd0) && (gnt_addr != 4'hF);
    ptr_nxt  = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
  end

  // Pointer advance, registered write port and error accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_sel   <= '0;
      wr_data  <= '0;
      addr_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      wr_en    <= 1'b0;
      wr_sel   <= '0;
      addr_err <= 1'b0;
      if (found) begin
        ptr <= ptr_nxt;
        if (addr_ok) begin
          wr_en   <= 1'b1;
          wr_addr <= gnt_addr;
          wr_sel  <= 14'd1 << (gnt_addr - 4'd1);
          wr_data <= gnt_data;
        end else begin
          addr_err <= 1'b1;
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (NREQ=3, DATA_W=8).
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [23:0] req_data;
  logic        rf_stall;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [13:0] wr_sel;
  logic [7:0]  wr_data;
  logic        addr_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter #(.NREQ(3), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_stall  (rf_stall),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .addr_err  (addr_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d);
    req_addr[4*i +: 4] = a;
    req_data[8*i +: 8] = d;
  endtask

  logic [31:0] sel_tab [3];
  logic [31:0] dat_tab [3];
  logic [3:0]  last_addr;
  logic [7:0]  last_data;
  int          g;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rf_stall  = 1'b0;
    tick();
    tick();
    check("rst_wr_en",   32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_sel",  32'(wr_sel), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_addr_err",32'(addr_err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_ready",   32'(req_ready), 0);
    rst_n = 1'b1;
    tick();

    // single requester 0, address 1
    set_req(0, 4'd1, 8'hA5);
    req_valid = 3'b001;
    #1;
    check("t1_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = 3'b000;
    check("t1_wr_en",   32'(wr_en), 1);
    check("t1_wr_addr", 32'(wr_addr), 1);
    check("t1_wr_sel",  32'(wr_sel), 32'h0001);
    check("t1_wr_data", 32'(wr_data), 32'hA5);

    // lone requester 2 with ptr=1, brings ptr back to 0
    set_req(2, 4'd5, 8'h3C);
    req_valid = 3'b100;
    #1;
    check("t1b_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = 3'b000;
    check("t1b_wr_sel",  32'(wr_sel), 32'h0010);
    check("t1b_wr_data", 32'(wr_data), 32'h3C);

    // all three valid: round-robin 0,1,2,0,1,2
    set_req(0, 4'd3,  8'h10);
    set_req(1, 4'd7,  8'h20);
    set_req(2, 4'd14, 8'h30);
    sel_tab[0] = 32'h0004; sel_tab[1] = 32'h0040; sel_tab[2] = 32'h2000;
    dat_tab[0] = 32'h10;   dat_tab[1] = 32'h20;   dat_tab[2] = 32'h30;
    req_valid = 3'b111;
    #1;
    for (int i = 0; i < 6; i++) begin
      g = i % 3;
      check("rr_ready", 32'(req_ready), 32'd1 << g);
      tick();
      check("rr_wr_en",   32'(wr_en), 1);
      check("rr_wr_sel",  32'(wr_sel), sel_tab[g]);
      check("rr_wr_data", 32'(wr_data), dat_tab[g]);
    end
    req_valid = 3'b000;
    tick();
    check("idle_wr_en",   32'(wr_en), 0);
    check("idle_wr_sel",  32'(wr_sel), 0);
    check("idle_wr_addr", 32'(wr_addr), 14);
    check("idle_wr_data", 32'(wr_data), 32'h30);

    // address sweep through requester 1
    last_addr = 4'd14;
    last_data = 8'h30;
    req_valid = 3'b010;
    for (int a = 0; a < 16; a++) begin
      set_req(1, 4'(a), 8'(8'h40 + a));
      #1;
      check("sw_ready", 32'(req_ready), 32'b010);
      tick();
      if (a >= 1 && a <= 14) begin
        last_addr = 4'(a);
        last_data = 8'(8'h40 + a);
        check("sw_wr_en",  32'(wr_en), 1);
        check("sw_wr_sel", 32'(wr_sel), 32'd1 << (a - 1));
        check("sw_err",    32'(addr_err), 0);
      end else begin
        check("sw_bad_wr_en",  32'(wr_en), 0);
        check("sw_bad_wr_sel", 32'(wr_sel), 0);
        check("sw_bad_err",    32'(addr_err), 1);
      end
      check("sw_wr_addr", 32'(wr_addr), 32'(last_addr));
      check("sw_wr_data", 32'(wr_data), 32'(last_data));
    end
    req_valid = 3'b000;
    tick();
    check("sw_err_cnt",  32'(err_cnt), 2);
    check("sw_err_idle", 32'(addr_err), 0);

    // stall with all valid; ptr is 2 and must hold
    set_req(0, 4'd3,  8'h10);
    set_req(1, 4'd7,  8'h20);
    set_req(2, 4'd14, 8'h30);
    req_valid = 3'b111;
    rf_stall  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("st_ready", 32'(req_ready), 0);
      tick();
      check("st_wr_en", 32'(wr_en), 0);
    end
    rf_stall = 1'b0;
    #1;
    check("st_resume_ready", 32'(req_ready), 32'b100);
    tick();
    rf_stall = 1'b1;
    #1;
    check("st_keep_wr_en",  32'(wr_en), 1);
    check("st_keep_wr_sel", 32'(wr_sel), 32'h2000);
    check("st_again_ready", 32'(req_ready), 0);
    tick();
    check("st_again_wr_en", 32'(wr_en), 0);
    rf_stall = 1'b0;
    #1;
    check("st_wrap_ready", 32'(req_ready), 32'b001);
    req_valid = 3'b000;
    tick();

    // error counter saturation: err_cnt starts at 2
    set_req(0, 4'd0, 8'hEE);
    req_valid = 3'b001;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 252) check("sat_pre", 32'(err_cnt), 254);
    end
    check("sat_cnt",   32'(err_cnt), 255);
    check("sat_err",   32'(addr_err), 1);
    check("sat_wr_en", 32'(wr_en), 0);
    req_valid = 3'b000;
    tick();
    check("sat_hold",     32'(err_cnt), 255);
    check("sat_err_idle", 32'(addr_err), 0);

    // reset mid-stream; ptr is 1 here
    set_req(0, 4'd2, 8'h5A);
    set_req(2, 4'd9, 8'h6B);
    req_valid = 3'b101;
    #1;
    check("mr_ready", 32'(req_ready), 32'b100);
    tick();
    check("mr_wr_en",   32'(wr_en), 1);
    check("mr_wr_addr", 32'(wr_addr), 9);
    rst_n = 1'b0;
    #1;
    check("mr_rst_wr_en",   32'(wr_en), 0);
    check("mr_rst_wr_sel",  32'(wr_sel), 0);
    check("mr_rst_wr_addr", 32'(wr_addr), 0);
    check("mr_rst_err_cnt", 32'(err_cnt), 0);
    check("mr_rst_ready",   32'(req_ready), 32'b001);
    tick();
    check("mr_in_rst_wr_en", 32'(wr_en), 0);
    rst_n = 1'b1;
    #1;
    check("mr_rel_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = 3'b000;
    check("mr_rel_wr_en",   32'(wr_en), 1);
    check("mr_rel_wr_addr", 32'(wr_addr), 2);
    check("mr_rel_wr_sel",  32'(wr_sel), 32'h0002);
    check("mr_rel_wr_data", 32'(wr_data), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
